// File: rtl/fetch_prefetch_if.sv
// Fetch-side bus bundle: memory instruction port plus the decode handshake.
// The fetch unit drives through master; memory and decode sit on slave.
interface fetch_prefetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        output mem_addr, mem_read, instr_valid, instr_data, instr_pc,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_addr, mem_read, instr_valid, instr_data, instr_pc,
        output mem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with a small prefetch FIFO, redirect flush and stall.
// Words return one cycle after the read and are queued with their PC.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_prefetch_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Credit counts the in-flight read; a pop this cycle frees nothing yet.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue = rst_n & fetch_en & ~redirect_valid
                 & (occupancy < {1'b0, FULL});
    assign push = inflight & ~redirect_valid;
    assign pop  = bus.instr_valid & bus.instr_ready & ~redirect_valid;

    assign bus.mem_read    = issue;
    assign bus.mem_addr    = fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = fifo[rd_ptr].data;
    assign bus.instr_pc    = fifo[rd_ptr].pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                inflight_pc <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo[wr_ptr] <= '{pc: inflight_pc, data: bus.mem_rdata};
        end
    end

    overflow_a: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == FULL)
    );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a stream-level model:
// words leave in PC order, two cycles after issue, with DEPTH credits.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    fetch_prefetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_prefetch_unit #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] memv [0:65535];

    always @(posedge clk) begin
        if (bus.mem_read === 1'b1) bus.mem_rdata <= memv[bus.mem_addr];
    end

    typedef struct {
        logic [15:0] pc;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    logic [15:0] next_pc;
    int          cyc;
    int          vectors;
    int          miscompares;

    logic        s_read, s_valid;
    logic [15:0] s_addr, s_pc, s_data;
    logic        exp_read, exp_valid;
    logic [15:0] exp_addr, exp_pc, exp_data;
    logic        fired;

    // One clock: drive, sample mid-cycle, then advance the reference model.
    task automatic tick(input logic fe, input logic rv, input logic [15:0] rpc,
                        input logic rdy, input logic rst);
        fetch_en = fe;
        redirect_valid = rv;
        redirect_pc = rpc;
        bus.instr_ready = rdy;
        rst_n = rst;
        @(negedge clk);
        s_read = bus.mem_read;
        s_valid = bus.instr_valid;
        s_addr = bus.mem_addr;
        s_pc = bus.instr_pc;
        s_data = bus.instr_data;
        exp_read = rst && fe && !rv && (q.size() < DEPTH);
        exp_addr = next_pc;
        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        exp_pc = 16'h0;
        exp_data = 16'h0;
        if (exp_valid) begin
            exp_pc = q[0].pc;
            exp_data = memv[q[0].pc];
        end
        fired = exp_valid && rdy && !rv && rst;
        if (!rst) begin
            q.delete();
            next_pc = RST_PC;
        end else if (rv) begin
            q.delete();
            next_pc = rpc;
        end else begin
            if (fired) void'(q.pop_front());
            if (exp_read) begin
                q.push_back('{pc: next_pc, cyc: cyc});
                next_pc = next_pc + 16'h1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if ({s_read, s_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ctl got read=%b valid=%b want 0 0", s_read, s_valid);
        end
        vectors++;
        if (s_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL reset_addr got %h want %h", s_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        for (int i = 0; i < 4; i++) memv[i] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && first < 0) first = i;
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL stream_ctl cyc=%0d got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         i, s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                vectors++;
                if ({s_pc, s_data} !== {exp_pc, exp_data}) begin
                    miscompares++;
                    $display("FAIL stream_word got %h/%h want %h/%h",
                             s_pc, s_data, exp_pc, exp_data);
                end
            end
        end
        vectors++;
        if (first != 2) begin
            miscompares++;
            $display("FAIL stream_latency got %0d want 2", first);
        end
    endtask

    task automatic test_backpressure();
        int first = -1;
        tick(1'b1, 1'b1, 16'h0010, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL bp_ctl got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
        end
        vectors++;
        if ({s_read, s_valid, s_addr} !== {1'b0, 1'b1, 16'h0014}) begin
            miscompares++;
            $display("FAIL bp_full got r=%b v=%b a=%h want r=0 v=1 a=0014",
                     s_read, s_valid, s_addr);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && first < 0) first = int'(s_pc);
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL bp_drain_ctl got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                vectors++;
                if ({s_pc, s_data} !== {exp_pc, exp_data}) begin
                    miscompares++;
                    $display("FAIL bp_word got %h/%h want %h/%h",
                             s_pc, s_data, exp_pc, exp_data);
                end
            end
        end
        vectors++;
        if (first != 16'h0010) begin
            miscompares++;
            $display("FAIL bp_first_pc got %h want 0010", first);
        end
    endtask

    task automatic test_redirect();
        int first = -1;
        tick(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 16'h0100, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        vectors++;
        if (s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_flush got valid=%b want 0", s_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && first < 0) first = int'(s_pc);
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL redirect_ctl got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                vectors++;
                if ({s_pc, s_data} !== {exp_pc, exp_data}) begin
                    miscompares++;
                    $display("FAIL redirect_word got %h/%h want %h/%h",
                             s_pc, s_data, exp_pc, exp_data);
                end
            end
        end
        vectors++;
        if (first != 16'h0100) begin
            miscompares++;
            $display("FAIL redirect_first_pc got %h want 0100", first);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want [4];
        logic [15:0] got [4];
        int n = 0;
        want[0] = 16'hFFFE; want[1] = 16'hFFFF;
        want[2] = 16'h0000; want[3] = 16'h0001;
        for (int i = 0; i < 4; i++) got[i] = 16'hDEAD;
        tick(1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && n < 4) begin
                got[n] = s_pc;
                n++;
            end
            if (exp_valid) begin
                vectors++;
                if ({s_valid, s_pc, s_data} !== {1'b1, exp_pc, exp_data}) begin
                    miscompares++;
                    $display("FAIL wrap_word got v=%b %h/%h want %h/%h",
                             s_valid, s_pc, s_data, exp_pc, exp_data);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL wrap_seq[%0d] got %h want %h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_fetch_en();
        logic seen = 1'b0;
        tick(1'b1, 1'b1, 16'h0200, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && s_pc === 16'h0200) seen = 1'b1;
            vectors++;
            if (s_read !== 1'b0) begin
                miscompares++;
                $display("FAIL fe_stall got read=%b want 0", s_read);
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL fe_inflight_word got seen=%b want 1", seen);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL fe_resume got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        tick(1'b1, 1'b1, 16'h0300, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        vectors++;
        if ({s_read, s_valid, s_addr} !== {1'b0, 1'b0, RST_PC}) begin
            miscompares++;
            $display("FAIL rst_mid got r=%b v=%b a=%h want r=0 v=0 a=%h",
                     s_read, s_valid, s_addr, RST_PC);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            if (s_valid === 1'b1 && first < 0) first = int'(s_pc);
        end
        vectors++;
        if (first != int'(RST_PC)) begin
            miscompares++;
            $display("FAIL rst_restart_pc got %h want %h", first, RST_PC);
        end
    endtask

    task automatic test_random();
        logic fe, rdy, rv;
        logic [15:0] rpc;
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 29) == 0);
            rpc = 16'($urandom);
            tick(fe, rv, rpc, rdy, 1'b1);
            vectors++;
            if ({s_read, s_valid, s_addr} !== {exp_read, exp_valid, exp_addr}) begin
                miscompares++;
                $display("FAIL rand_ctl i=%0d got r=%b v=%b a=%h want r=%b v=%b a=%h",
                         i, s_read, s_valid, s_addr, exp_read, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                vectors++;
                if ({s_pc, s_data} !== {exp_pc, exp_data}) begin
                    miscompares++;
                    $display("FAIL rand_word i=%0d got %h/%h want %h/%h",
                             i, s_pc, s_data, exp_pc, exp_data);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        next_pc = RST_PC;
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0;
        bus.instr_ready = 1'b0;
        bus.mem_rdata = 16'h0;
        for (int i = 0; i < 65536; i++) memv[i] = 16'($urandom);
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
